// File: rtl/reorder_buffer.sv
// Seven-entry circular reorder buffer: allocates tags 1..7 at issue, captures
// writeback results, serves tag-indexed operand lookup and retires in program order.
module reorder_buffer #(
   parameter int DEPTH = 7,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   output logic            issue_ready,
   output logic [2:0]      issue_tag,
   input  logic            wb_valid,
   input  logic [2:0]      wb_tag,
   input  logic [XLEN-1:0] wb_data,
   input  logic [2:0]      q1_tag,
   input  logic [2:0]      q2_tag,
   output logic            q1_ready,
   output logic            q2_ready,
   output logic [XLEN-1:0] q1_data,
   output logic [XLEN-1:0] q2_data,
   output logic            commit,
   output logic [4:0]      commit_reg,
   output logic [XLEN-1:0] commit_data,
   output logic [2:0]      commit_tag
);

   localparam logic [2:0] LastIdx   = 3'(DEPTH - 1);
   localparam logic [3:0] FullCount = 4'(DEPTH);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [4:0]       rd_q   [DEPTH];
   logic [4:0]       rd_d   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [XLEN-1:0]  data_d [DEPTH];
   logic [2:0]       head_q, head_d;
   logic [2:0]       tail_q, tail_d;
   logic [3:0]       count_q, count_d;

   logic             commit_q, commit_d;
   logic [4:0]       commitReg_q, commitReg_d;
   logic [XLEN-1:0]  commitData_q, commitData_d;
   logic [2:0]       commitTag_q, commitTag_d;

   logic             issueFire;
   logic             retireFire;

   function automatic logic [2:0] nextPtr(input logic [2:0] p);
      return (p == LastIdx) ? 3'd0 : p + 3'd1;
   endfunction

   assign issue_ready = (count_q < FullCount);
   assign issue_tag   = tail_q + 3'd1;
   assign issueFire   = issue_valid && issue_ready;
   assign retireFire  = busy_q[head_q] && done_q[head_q];

   // Next-state: writeback capture, head retirement, tail allocation; flush overrides all.
   always_comb begin
      busy_d       = busy_q;
      done_d       = done_q;
      rd_d         = rd_q;
      data_d       = data_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      commit_d     = 1'b0;
      commitReg_d  = commitReg_q;
      commitData_d = commitData_q;
      commitTag_d  = commitTag_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (wb_valid && wb_tag == 3'(i + 1) && busy_q[i] && !done_q[i]) begin
            data_d[i] = wb_data;
            done_d[i] = 1'b1;
         end
      end

      if (retireFire) begin
         commit_d     = 1'b1;
         commitReg_d  = rd_q[head_q];
         commitTag_d  = head_q + 3'd1;
         commitData_d = (rd_q[head_q] == 5'd0) ? '0 : data_q[head_q];
         busy_d[head_q] = 1'b0;
         done_d[head_q] = 1'b0;
         head_d         = nextPtr(head_q);
      end

      if (issueFire) begin
         busy_d[tail_q] = 1'b1;
         done_d[tail_q] = 1'b0;
         rd_d[tail_q]   = issue_rd;
         tail_d         = nextPtr(tail_q);
      end

      case ({issueFire, retireFire})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase

      if (flush) begin
         busy_d       = '0;
         done_d       = '0;
         head_d       = 3'd0;
         tail_d       = 3'd0;
         count_d      = 4'd0;
         commit_d     = 1'b0;
         commitReg_d  = 5'd0;
         commitData_d = '0;
         commitTag_d  = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q       <= '0;
         done_q       <= '0;
         head_q       <= 3'd0;
         tail_q       <= 3'd0;
         count_q      <= 4'd0;
         commit_q     <= 1'b0;
         commitReg_q  <= 5'd0;
         commitData_q <= '0;
         commitTag_q  <= 3'd0;
      end else begin
         busy_q       <= busy_d;
         done_q       <= done_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         commit_q     <= commit_d;
         commitReg_q  <= commitReg_d;
         commitData_q <= commitData_d;
         commitTag_q  <= commitTag_d;
      end
   end

   // Payload storage needs no reset; busy/done qualify every read.
   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

   assign commit      = commit_q;
   assign commit_reg  = commitReg_q;
   assign commit_data = commitData_q;
   assign commit_tag  = commitTag_q;

   // Operand lookup with a same-cycle bypass from the writeback bus.
   always_comb begin
      q1_ready = 1'b0;
      q1_data  = '0;
      q2_ready = 1'b0;
      q2_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (busy_q[i] && q1_tag == 3'(i + 1)) begin
            if (done_q[i]) begin
               q1_ready = 1'b1;
               q1_data  = data_q[i];
            end else if (wb_valid && wb_tag == q1_tag) begin
               q1_ready = 1'b1;
               q1_data  = wb_data;
            end
         end
         if (busy_q[i] && q2_tag == 3'(i + 1)) begin
            if (done_q[i]) begin
               q2_ready = 1'b1;
               q2_data  = data_q[i];
            end else if (wb_valid && wb_tag == q2_tag) begin
               q2_ready = 1'b1;
               q2_data  = wb_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order retirement, full/wrap,
// x0 destination, operand bypass and flush recovery.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        issueValid;
   logic [4:0]  issueRd;
   logic        issueReady;
   logic [2:0]  issueTag;
   logic        wbValid;
   logic [2:0]  wbTag;
   logic [31:0] wbData;
   logic [2:0]  q1Tag, q2Tag;
   logic        q1Ready, q2Ready;
   logic [31:0] q1Data, q2Data;
   logic        commit;
   logic [4:0]  commitReg;
   logic [31:0] commitData;
   logic [2:0]  commitTag;

   int nCompared   = 0;
   int nMismatched = 0;

   reorder_buffer #(.DEPTH(7), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issueValid), .issue_rd(issueRd),
      .issue_ready(issueReady), .issue_tag(issueTag),
      .wb_valid(wbValid), .wb_tag(wbTag), .wb_data(wbData),
      .q1_tag(q1Tag), .q2_tag(q2Tag),
      .q1_ready(q1Ready), .q2_ready(q2Ready),
      .q1_data(q1Data), .q2_data(q2Data),
      .commit(commit), .commit_reg(commitReg),
      .commit_data(commitData), .commit_tag(commitTag)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits past the next edge, then presents inputs for the following edge.
   task automatic applyStimulus(input logic iv, input logic [4:0] rd,
                                input logic wv, input logic [2:0] wt, input logic [31:0] wd);
      @(posedge clk);
      #1;
      issueValid = iv;
      issueRd    = rd;
      wbValid    = wv;
      wbTag      = wt;
      wbData     = wd;
      #1;
   endtask

   task automatic resetDut();
      rst        = 1'b0;
      flush      = 1'b0;
      issueValid = 1'b0;
      issueRd    = 5'd0;
      wbValid    = 1'b0;
      wbTag      = 3'd0;
      wbData     = 32'd0;
      q1Tag      = 3'd0;
      q2Tag      = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
   endtask

   initial begin
      $display("[TB] starting reorder_buffer bench");

      // Reset state
      resetDut();
      q1Tag = 3'd1;
      q2Tag = 3'd2;
      #1;
      checkOutput("rst_issue_ready", 32'(issueReady), 32'd1);
      checkOutput("rst_issue_tag",   32'(issueTag),   32'd1);
      checkOutput("rst_commit",      32'(commit),     32'd0);
      checkOutput("rst_q1_ready",    32'(q1Ready),    32'd0);
      checkOutput("rst_q2_ready",    32'(q2Ready),    32'd0);

      // In-order retirement despite out-of-order writeback
      applyStimulus(1'b1, 5'd5, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_tag1", 32'(issueTag), 32'd1);
      applyStimulus(1'b1, 5'd6, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_tag2", 32'(issueTag), 32'd2);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd2, 32'h0000BEEF);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'h00001234);
      q1Tag = 3'd2;
      #1;
      checkOutput("ooo_no_commit_a", 32'(commit), 32'd0);
      checkOutput("ooo_q1_done_rdy", 32'(q1Ready), 32'd1);
      checkOutput("ooo_q1_done_dat", q1Data, 32'h0000BEEF);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_no_commit_b", 32'(commit), 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_c1_commit", 32'(commit),    32'd1);
      checkOutput("ooo_c1_reg",    32'(commitReg), 32'd5);
      checkOutput("ooo_c1_data",   commitData,     32'h00001234);
      checkOutput("ooo_c1_tag",    32'(commitTag), 32'd1);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_c2_commit", 32'(commit),    32'd1);
      checkOutput("ooo_c2_reg",    32'(commitReg), 32'd6);
      checkOutput("ooo_c2_data",   commitData,     32'h0000BEEF);
      checkOutput("ooo_c2_tag",    32'(commitTag), 32'd2);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("ooo_idle_commit", 32'(commit),   32'd0);
      checkOutput("ooo_idle_tag",    32'(issueTag), 32'd3);

      // Full buffer, simultaneous issue/retire and tail wrap
      resetDut();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0);
         checkOutput("fill_tag",   32'(issueTag),   32'(i + 1));
         checkOutput("fill_ready", 32'(issueReady), 32'd1);
      end
      applyStimulus(1'b1, 5'd9, 1'b1, 3'd1, 32'h00000011);
      checkOutput("full_ready", 32'(issueReady), 32'd0);
      checkOutput("full_tag",   32'(issueTag),   32'd1);
      applyStimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'd0);
      checkOutput("full_ready_b",  32'(issueReady), 32'd0);
      checkOutput("full_no_commit", 32'(commit),    32'd0);
      applyStimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'd0);
      checkOutput("ret_commit",    32'(commit),     32'd1);
      checkOutput("ret_tag",       32'(commitTag),  32'd1);
      checkOutput("ret_reg",       32'(commitReg),  32'd1);
      checkOutput("ret_data",      commitData,      32'h00000011);
      checkOutput("ret_rejected",  32'(issueReady), 32'd1);
      checkOutput("wrap_tag",      32'(issueTag),   32'd1);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("wrap_accepted", 32'(issueTag),   32'd2);
      checkOutput("wrap_full",     32'(issueReady), 32'd0);
      checkOutput("wrap_commit",   32'(commit),     32'd0);

      // x0 destination retires with zero data
      resetDut();
      applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'hFFFFFFFF);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("x0_commit", 32'(commit),    32'd1);
      checkOutput("x0_reg",    32'(commitReg), 32'd0);
      checkOutput("x0_data",   commitData,     32'd0);
      checkOutput("x0_tag",    32'(commitTag), 32'd1);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("hold_commit", 32'(commit),    32'd0);
      checkOutput("hold_tag",    32'(commitTag), 32'd1);

      // Operand bypass from the writeback bus
      resetDut();
      applyStimulus(1'b1, 5'd1, 1'b0, 3'd0, 32'd0);
      applyStimulus(1'b1, 5'd2, 1'b0, 3'd0, 32'd0);
      applyStimulus(1'b1, 5'd3, 1'b0, 3'd0, 32'd0);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      q1Tag = 3'd3;
      q2Tag = 3'd0;
      #1;
      checkOutput("byp_pending_rdy", 32'(q1Ready), 32'd0);
      checkOutput("byp_pending_dat", q1Data,       32'd0);
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd3, 32'hA5A5A5A5);
      checkOutput("byp_q1_ready", 32'(q1Ready), 32'd1);
      checkOutput("byp_q1_data",  q1Data,       32'hA5A5A5A5);
      checkOutput("byp_q2_ready", 32'(q2Ready), 32'd0);
      checkOutput("byp_q2_data",  q2Data,       32'd0);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("byp_done_ready", 32'(q1Ready), 32'd1);
      checkOutput("byp_done_data",  q1Data,       32'hA5A5A5A5);

      // Flush with the head entry done discards everything
      resetDut();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'd0);
      end
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'h00000077);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      flush = 1'b1;
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      flush = 1'b0;
      q1Tag = 3'd1;
      #1;
      checkOutput("flush_commit",   32'(commit),     32'd0);
      checkOutput("flush_tag",      32'(issueTag),   32'd1);
      checkOutput("flush_ready",    32'(issueReady), 32'd1);
      checkOutput("flush_q1_ready", 32'(q1Ready),    32'd0);
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("flush_commit_b", 32'(commit), 32'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 5'd1, 1'b0, 3'd0, 32'd0);
         checkOutput("refill_tag",   32'(issueTag),   32'(i + 1));
         checkOutput("refill_ready", 32'(issueReady), 32'd1);
      end
      applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0);
      checkOutput("refill_full", 32'(issueReady), 32'd0);
      checkOutput("refill_wrap", 32'(issueTag),   32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer of 7 entries, addressed by 3-bit tags 1..7. Tag 0 means "no producer".
- Allocates the tag that the register file records as a destination's dependency at issue time.
- Captures results from the writeback bus and provides tag-indexed operand lookup for issuing instructions.
- Drives the register file commit interface in program order, at most one entry per cycle.

Parameters:
- DEPTH, 7, number of entries. Fixed by the 3-bit tag with 0 reserved; other values are unsupported.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
- flush  in  1  discard all entries (mispredict recovery).
- issue_valid  in  1  new instruction is allocating an entry this cycle.
- issue_rd  in  5  destination register; 0 means no destination.
- issue_ready  out  1  combinational; equals count<7.
- issue_tag  out  3  combinational; tail index+1. This is the tag allocated if the issue is accepted.
- wb_valid  in  1  writeback bus valid.
- wb_tag  in  3  writeback producer tag.
- wb_data  in  XLEN  writeback result.
- q1_tag, q2_tag  in  3 each  operand producer tags to resolve.
- q1_ready, q2_ready  out  1 each  combinational; the result for that tag is available.
- q1_data, q2_data  out  XLEN each  combinational; result value, 0 when not ready.
- commit  out  1  registered; one-cycle pulse per retired entry.
- commit_reg  out  5  registered; architectural destination register.
- commit_data  out  XLEN  registered; value to write.
- commit_tag  out  3  registered; tag being retired, used by the register file to clear a matching dependency.

Behaviour:
- State:
  - Per entry: busy, done, rd[4:0], data[XLEN-1:0].
  - head and tail, each 0..6, wrapping 6 to 0.
  - count, 0..7.
  - Tag of entry i is i+1.
- Reset (rst==0) or flush==1 at posedge:
  - All busy/done cleared; head=tail=count=0.
  - commit=0, commit_reg=0, commit_data=0, commit_tag=0.
  - Issue, writeback and retirement in that same cycle are ignored.
  - Reset/flush mid-operation discards everything in flight, with no partial commit.
- Issue:
  - Accepted when issue_valid && issue_ready.
  - Entry[tail] gets busy=1, done=0, rd=issue_rd; tail advances; count increments.
  - issue_valid while full: no state change, no error.
- Writeback:
  - When wb_valid, wb_tag!=0 and entry[wb_tag-1] is busy and not done: data=wb_data, done=1.
  - Writeback to tag 0, to a non-busy entry, or to an already-done entry is ignored.
- Retirement:
  - Occurs at a posedge when entry[head] is busy and done, evaluated on pre-edge state.
  - Outputs become commit=1, commit_reg=rd, commit_tag=head+1, and commit_data=data, except commit_data=0 when rd==0. This keeps a retired x0 write harmless.
  - The entry is cleared; head advances; count decrements.
  - Otherwise commit=0, while the other commit outputs hold their last values.
- Latency:
  - Writeback sampled at edge k gives retirement visible after edge k+1, provided the entry is at head.
  - There is no same-edge writeback-to-commit bypass.
- Simultaneous events:
  - Issue and retire on the same edge: count unchanged.
  - issue_ready uses the pre-edge count, so a full buffer does not accept an issue even while retiring.
  - Writeback to the head tag and retirement of an older entry cannot coincide.
  - Writeback to a tag being allocated on the same edge is impossible because that entry is not busy, so it is ignored.
- Operand lookup, combinational, for each port independently:
  - If tag==0 or the entry is not busy: ready=0, data=0.
  - If the entry is done: ready=1, data=entry data.
  - Else if wb_valid && wb_tag==tag: ready=1, data=wb_data (writeback bypass).
  - Else: ready=0, data=0.
- Wrap-around:
  - Pointers wrap independently.
  - count distinguishes full (7) from empty (0) when head==tail.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 2 cycles, then release.
  - Required: issue_ready=1, issue_tag=1, commit=0, all q*_ready=0.
- In-order retirement despite out-of-order writeback:
  - Stimulus: issue rd=5 (tag1) and rd=6 (tag2); writeback tag2=0xBEEF, then tag1=0x1234.
  - Required: commit with reg5/0x1234/tag1, then on the next cycle reg6/0xBEEF/tag2.
  - Required: no commit before tag1 is done.
- Full, wrap and simultaneous issue/retire:
  - Stimulus: issue 7 entries; issue a further instruction (the extra issue); complete tag1; keep issue_valid high.
  - Required: the extra issue is not accepted and issue_ready=0.
  - Required: the edge that retires tag1 still rejects the issue.
  - Required: the next cycle accepts it with issue_tag=1 (wrap).
- x0 destination:
  - Stimulus: issue rd=0; writeback 0xFFFFFFFF.
  - Required: commit=1, commit_reg=0, commit_data=0.
- Operand bypass:
  - Stimulus: tag3 busy and not done; q1_tag=3; wb_valid with tag3, data 0xA5A5A5A5 in the same cycle.
  - Required: q1_ready=1 and q1_data=0xA5A5A5A5 combinationally.
  - Required: q2_tag=0 gives q2_ready=0.
- Flush mid-operation:
  - Stimulus: 4 entries in flight, head entry done, flush=1 at that edge.
  - Required: no commit pulse; count=0; next issue_tag=1.
